sram_responder: RTL

On-chip emulation of the DE2-115 asynchronous 16-bit SRAM, seen from the chip side of the pins. The delay-line and effects engines can be brought up and simulated without the external IS61WV102416 part. It sits where the SRAM pins would be and answers the same nCE/nOE/nWE/nUB/nLB/address/data bus the delay taps drive. Storage is block RAM, sampled and driven synchronously on the 50 MHz system clock.

---
 rtl/sram_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// On-chip stand-in for the DE2-115 asynchronous 16-bit SRAM, answering the pin-level bus from block RAM.
// Optional power-up scrub to zero is compiled in with SRAM_RESP_SCRUB_EN.
module sram_responder #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic        CLOCK50,
    input  logic        RESET,
    input  logic [19:0] SRAMaddress,
    input  logic        SRAM_nCE,
    input  logic        SRAM_nOE,
    input  logic        SRAM_nWE,
    input  logic        SRAM_nUB,
    input  logic        SRAM_nLB,
    inout  wire  [15:0] SRAMdata,
    output logic        BUSY,
    output logic [15:0] WRCOUNT,
    output logic [15:0] RDCOUNT
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Overlay freshly committed lanes onto the RAM word read in the same cycle.
    function automatic logic [15:0] mergeLanes(
        input logic [15:0] ramWord,
        input logic [15:0] newWord,
        input logic [1:0]  lanes
    );
        mergeLanes[15:8] = lanes[1] ? newWord[15:8] : ramWord[15:8];
        mergeLanes[7:0]  = lanes[0] ? newWord[7:0]  : ramWord[7:0];
    endfunction

    logic [19:0]           sAddr_r;
    logic [15:0]           sData_r;
    logic                  sNce_r, sNoe_r, sNwe_r, sNub_r, sNlb_r;
    logic [ADDR_WIDTH-1:0] holdAddr_r;
    logic [15:0]           holdData_r;
    logic [1:0]            holdLanes_r;
    logic                  holdValid_r;
    logic                  rdPrev_r;
    logic [19:0]           prevAddr_r;
    logic [15:0]           wrCount_r, rdCount_r;
    logic [15:0]           mem [DEPTH];
    logic [15:0]           ramQ_r;
    logic [1:0]            rEn_r, oEn_r;
    logic                  bypHit_r;
    logic [15:0]           bypData_r, oData_r;
    logic [1:0]            bypLanes_r;

    logic                  busy_s, wrActive_s, rdActive_s, commit_s, rdStart_s;
    logic [ADDR_WIDTH-1:0] rAddr_s, scrubAddr_s, memWaddr_s;
    logic [1:0]            memWe_s;
    logic [15:0]           memWdata_s;

`ifdef SRAM_RESP_SCRUB_EN
    logic                  busy_r;
    logic [ADDR_WIDTH-1:0] scrubAddr_r;

    // Scrub sweep: one zero word per cycle from reset release; busy drops after the last word.
    always_ff @(posedge CLOCK50 or negedge RESET) begin
        if (!RESET) begin
            busy_r      <= 1'b1;
            scrubAddr_r <= {ADDR_WIDTH{1'b0}};
        end else if (busy_r) begin
            scrubAddr_r <= scrubAddr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            busy_r      <= (scrubAddr_r != {ADDR_WIDTH{1'b1}});
        end else begin
            busy_r      <= 1'b0;
            scrubAddr_r <= scrubAddr_r;
        end
    end

    assign busy_s      = busy_r;
    assign scrubAddr_s = scrubAddr_r;
`else
    assign busy_s      = 1'b0;
    assign scrubAddr_s = {ADDR_WIDTH{1'b0}};
`endif

    // Stage S: register every pin; controls reset to the idle (deasserted) level.
    always_ff @(posedge CLOCK50 or negedge RESET) begin
        if (!RESET) begin
            sAddr_r <= 20'h00000;
            sData_r <= 16'h0000;
            sNce_r  <= 1'b1;
            sNoe_r  <= 1'b1;
            sNwe_r  <= 1'b1;
            sNub_r  <= 1'b1;
            sNlb_r  <= 1'b1;
        end else begin
            sAddr_r <= SRAMaddress;
            sData_r <= SRAMdata;
            sNce_r  <= SRAM_nCE;
            sNoe_r  <= SRAM_nOE;
            sNwe_r  <= SRAM_nWE;
            sNub_r  <= SRAM_nUB;
            sNlb_r  <= SRAM_nLB;
        end
    end

    // nWE low wins over nOE low, so an overlapped cycle is a write and never drives the bus.
    assign wrActive_s = !sNce_r && !sNwe_r && !busy_s;
    assign rdActive_s = !sNce_r && !sNoe_r && sNwe_r && !busy_s;
    assign commit_s   = holdValid_r && !wrActive_s;
    assign rdStart_s  = rdActive_s && (!rdPrev_r || (sAddr_r != prevAddr_r));
    assign rAddr_s    = sAddr_r[ADDR_WIDTH-1:0];

    // Write-hold: the master moves the address as nWE rises, so commit from the last active sample.
    always_ff @(posedge CLOCK50 or negedge RESET) begin
        if (!RESET) begin
            holdAddr_r  <= {ADDR_WIDTH{1'b0}};
            holdData_r  <= 16'h0000;
            holdLanes_r <= 2'b00;
            holdValid_r <= 1'b0;
        end else if (wrActive_s) begin
            holdAddr_r  <= sAddr_r[ADDR_WIDTH-1:0];
            holdData_r  <= sData_r;
            holdLanes_r <= {~sNub_r, ~sNlb_r};
            holdValid_r <= 1'b1;
        end else if (commit_s) begin
            holdValid_r <= 1'b0;
        end else begin
            holdValid_r <= holdValid_r;
        end
    end

    // Access counters and read-start edge tracking.
    always_ff @(posedge CLOCK50 or negedge RESET) begin
        if (!RESET) begin
            wrCount_r  <= 16'h0000;
            rdCount_r  <= 16'h0000;
            rdPrev_r   <= 1'b0;
            prevAddr_r <= 20'h00000;
        end else begin
            wrCount_r  <= commit_s  ? wrCount_r + 16'd1 : wrCount_r;
            rdCount_r  <= rdStart_s ? rdCount_r + 16'd1 : rdCount_r;
            rdPrev_r   <= rdActive_s;
            prevAddr_r <= sAddr_r;
        end
    end

    // Single RAM write port shared between scrub and normal commits.
    always_comb begin
        memWe_s    = busy_s ? 2'b11 : (commit_s ? holdLanes_r : 2'b00);
        memWaddr_s = busy_s ? scrubAddr_s : holdAddr_r;
        memWdata_s = busy_s ? 16'h0000 : holdData_r;
    end

    // Block RAM with byte-lane writes and a registered, read-before-write read port.
    always_ff @(posedge CLOCK50) begin
        if (memWe_s[1]) begin
            mem[memWaddr_s][15:8] <= memWdata_s[15:8];
        end
        if (memWe_s[0]) begin
            mem[memWaddr_s][7:0] <= memWdata_s[7:0];
        end
        ramQ_r <= mem[rAddr_s];
    end

    // Stage R/O: drive enables travel with the data; bypass covers a commit landing on the read cycle.
    always_ff @(posedge CLOCK50 or negedge RESET) begin
        if (!RESET) begin
            rEn_r      <= 2'b00;
            bypHit_r   <= 1'b0;
            bypData_r  <= 16'h0000;
            bypLanes_r <= 2'b00;
            oEn_r      <= 2'b00;
            oData_r    <= 16'h0000;
        end else begin
            rEn_r      <= rdActive_s ? {~sNub_r, ~sNlb_r} : 2'b00;
            bypHit_r   <= commit_s && (holdAddr_r == rAddr_s);
            bypData_r  <= holdData_r;
            bypLanes_r <= holdLanes_r;
            oEn_r      <= rEn_r;
            oData_r    <= mergeLanes(ramQ_r, bypData_r, bypHit_r ? bypLanes_r : 2'b00);
        end
    end

    assign SRAMdata[15:8] = oEn_r[1] ? oData_r[15:8] : 8'hzz;
    assign SRAMdata[7:0]  = oEn_r[0] ? oData_r[7:0]  : 8'hzz;
    assign BUSY    = busy_s;
    assign WRCOUNT = wrCount_r;
    assign RDCOUNT = rdCount_r;

endmodule
